// File: rtl/updown_dir_ctrl.sv
// Direction/enable controller for the mod-N up/down counter: syncs and debounces btn_dir/btn_hold.
// Optional feature macro AUTO_REVERSE_EN: direction bounces at count_in limits 0 and N-1.
module updown_dir_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int N               = 10,
   parameter int CNT_W           = 4,
   parameter bit INIT_DIR        = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_dir,
   input  logic             btn_hold,
   input  logic [CNT_W-1:0] count_in,
   output logic             upordown,
   output logic             enable,
   output logic             dir_changed
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int DIR  = 0;
   localparam int HOLD = 1;

   typedef enum logic {REL, PRS} dir_state_t;

   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      stable;
   logic [DB_W-1:0] db_cnt [2];
   dir_state_t      state;
   dir_state_t      state_next;
   logic            press;
   logic            upordown_next;
   logic            dir_changed_next;

   // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {btn_hold, btn_dir};
         sync2 <= sync1;
      end
   end

   // NOTE: the small counter array is reset element by element; it is control state, not storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable    <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
   always_comb begin
      state_next = state;
      press      = 1'b0;
      case (state)
         REL: if (stable[DIR]) begin
            state_next = PRS;
            press      = 1'b1;
         end
         PRS: if (!stable[DIR]) state_next = REL;
         default: state_next = REL;
      endcase
   end

`ifdef AUTO_REVERSE_EN
   // Auto-reverse is evaluated after the button so it overrides a coincident toggle.
   always_comb begin
      upordown_next = press ? ~upordown : upordown;
      if (enable) begin
         if (upordown && count_in == CNT_W'(N - 1)) upordown_next = 1'b0;
         else if (!upordown && count_in == '0)      upordown_next = 1'b1;
      end
      dir_changed_next = (upordown_next != upordown);
   end
`else
   logic unused_count_in;
   assign unused_count_in = ^count_in;

   always_comb begin
      upordown_next    = press ? ~upordown : upordown;
      dir_changed_next = press;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= REL;
         upordown    <= INIT_DIR;
         enable      <= 1'b1;
         dir_changed <= 1'b0;
      end else begin
         state       <= state_next;
         upordown    <= upordown_next;
         enable      <= ~stable[HOLD];
         dir_changed <= dir_changed_next;
      end
   end

endmodule
